cla_nibble_seq: RTL
===================

# cla_nibble_seq

Multi-cycle, WIDTH-bit add/subtract sequencer built around one shared 4-bit carry-lookahead adder slice. Each cycle it processes one nibble, least significant first, and feeds the carry-out of that nibble into the next. This trades latency for area in small datapaths. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, ≥ 8
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/command present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- cin  in  1  carry-in; used only when sub = 0
- sub  in  1  1 = compute a − b
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  final carry-out; for subtraction, 1 = no borrow
- overflow  out  1  signed (two's-complement) overflow
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready, capture the operands:
    - A_reg ← a
    - B_reg ← sub ? ~b : b
    - carry ← sub ? 1 : cin
    - msb flags for overflow: a[WIDTH-1] and (sub ? ~b : b)[WIDTH-1]
    - nibble counter ← 0
  - Go to RUN.
- RUN
  - One nibble per cycle: the slice adds A_reg[3:0], B_reg[3:0] and carry.
  - A_reg and B_reg shift right by 4.
  - The slice sum nibble shifts into the top of the result register; the result register shifts right by 4.
  - carry ← slice carry-out.
  - The counter increments. When the counter reaches N−1, where N = WIDTH/4, go to DONE.
- DONE
  - out_valid = 1. sum, cout and overflow are stable until the handshake.
  - cout = final carry.
  - overflow = (a_msb == b'_msb) & (sum[WIDTH-1] ≠ a_msb).
  - On out_valid & out_ready, go to IDLE.
- in_ready = 0 in RUN and DONE. There is no overlap of operations.
- Inputs a, b, cin and sub are sampled only at the accept edge. Changes on them at any other time have no effect.
- Arithmetic is modulo 2^WIDTH. A result of all zeros is legal.
- Reset, from any state including mid-RUN or DONE:
  - Go to IDLE.
  - out_valid = 0, sum = 0, cout = 0, overflow = 0, busy = 0.
  - The in-flight operation is discarded and no result is produced.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.

## Timing
- Accept edge E0 is the first edge with in_valid & in_ready.
- RUN occupies N cycles, edges E0+1 … E0+N. out_valid rises after edge E0+N.
  - Latency from accept to out_valid is N cycles: 4 for WIDTH = 16.
- If out_ready = 1 in the first DONE cycle, the block returns to IDLE at the next edge. The next accept is possible one cycle later.
  - Minimum issue interval is N+2 cycles.
- out_ready low: DONE is held indefinitely and the outputs do not change.
- out_ready high in IDLE or RUN is ignored.
- in_valid high in RUN or DONE is ignored; the producer must hold in_valid until in_ready.
- rst has priority over every handshake in the same cycle.
- The critical path is one 4-bit carry-lookahead slice plus the register setup time.

## Structure
- Shared package cla_pkg contains:
  - state enum {IDLE, RUN, DONE}
  - localparam NIBBLE = 4
  - counter-width function clog2(WIDTH/NIBBLE)
- One sub-module: the team's existing 4-bit carry-lookahead adder cla4 (a, b, cin, sum, cout). It is instantiated once and is purely combinational.
- All sequencing, shifting and overflow logic lives in cla_nibble_seq.

## Test plan
All scenarios use WIDTH = 16.
- 0x1234 + 0x1111, cin = 0, sub = 0, out_ready = 1 → out_valid 4 cycles after accept; sum = 0x2345, cout = 0, overflow = 0.
- 0xFFFF + 0x0001, cin = 0 → sum = 0x0000, cout = 1, overflow = 0. Also 0x00FF + 0x0000, cin = 1 → 0x0100, which checks carry propagation across nibbles.
- 0x7FFF + 0x0001 → sum = 0x8000, overflow = 1, cout = 0. Also 0x8000 − 0x0001 (sub = 1) → 0x7FFF, overflow = 1, cout = 1.
- 0x0005 − 0x0007 (sub = 1, cin = 1 ignored) → sum = 0xFFFE, cout = 0, overflow = 0.
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE → outputs stable and in_ready = 0. Toggle a and b during RUN → result unchanged. Accept again 2 cycles after the output handshake.
- Assert rst during the 2nd RUN cycle → next cycle IDLE with out_valid = 0 and sum = 0. No stale result appears. A new operation, 0x0001 + 0x0001 → 0x0002, completes normally.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead add/subtract sequencer.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2 used to size the nibble counter; callers always pass values >= 2.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [4:0] c_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  // Every carry is expanded directly from generate/propagate, so no ripple through the slice.
  assign c_s[0] = cin;
  assign c_s[1] = g_s[0] | (p_s[0] & cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

  assign sum  = p_s ^ c_s[3:0];
  assign cout = c_s[4];

endmodule

// File: rtl/cla_nibble_seq.sv
// WIDTH-bit add/subtract sequencer reusing one 4-bit CLA slice, one nibble per cycle, LSB first.
module cla_nibble_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int N     = WIDTH / NIBBLE;
  localparam int CNT_W = clog2(N);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic               a_msb_q;
  logic               b_msb_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   b_eff_s;
  logic [NIBBLE-1:0]  slice_sum_s;
  logic               slice_cout_s;
  logic               accept_s;
  logic               last_s;

  cla4 u_cla4 (
    .a    (a_q[NIBBLE-1:0]),
    .b    (b_q[NIBBLE-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Subtraction is a + ~b + 1, so the inversion and forced carry happen once at capture.
  always_comb begin
    b_eff_s  = b;
    accept_s = 1'b0;
    last_s   = 1'b0;
    if (sub) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    if ((state_q == IDLE) && in_valid && !rst) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (cnt_q == CNT_W'(N - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Sequencer state, operand shifters, result shifter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            a_q     <= a;
            b_q     <= b_eff_s;
            carry_q <= sub ? 1'b1 : cin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff_s[WIDTH-1];
            ovf_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= {{NIBBLE{1'b0}}, a_q[WIDTH-1:NIBBLE]};
          b_q     <= {{NIBBLE{1'b0}}, b_q[WIDTH-1:NIBBLE]};
          res_q   <= {slice_sum_s, res_q[WIDTH-1:NIBBLE]};
          carry_q <= slice_cout_s;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_s) begin
            // The final slice's top bit is the result sign bit.
            ovf_q   <= (a_msb_q == b_msb_q) && (slice_sum_s[NIBBLE-1] != a_msb_q);
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = res_q;
  assign cout      = carry_q;
  assign overflow  = ovf_q;

endmodule
